// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: time-shares one ALU and one memory port across
// fetch/decode/execute/memory/writeback, driving every datapath select and enable.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       reg_write,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'h0,
    S_DECODE    = 4'h1,
    S_MEM_ADR   = 4'h2,
    S_MEM_READ  = 4'h3,
    S_MEM_WB    = 4'h4,
    S_MEM_WRITE = 4'h5,
    S_EXEC_R    = 4'h6,
    S_EXEC_I    = 4'h7,
    S_ALU_WB    = 4'h8,
    S_BRANCH    = 4'h9,
    S_JAL       = 4'hA,
    S_JALR      = 4'hB,
    S_JALR_LINK = 4'hC,
    S_LUI       = 4'hD,
    S_HALT      = 4'hF
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm here, which is already the AUIPC result
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_ALU_WB;
          OP_SYSTEM:          state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        retire  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link OldPC + 4
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/outputs are
// queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       reg_write, retire, halted, illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       tk;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .reg_write(reg_write), .retire(retire), .halted(halted), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [16:0] outs;
  assign outs = {mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
                 alu_op, result_src, reg_write, retire, halted, illegal};

  // Reference decode of the per-state output table
  function automatic logic [16:0] exp_out(logic [3:0] st, logic rdy, logic tk, logic ill);
    logic req = 0, we = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ret = 0, hlt = 0;
    logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00, rs = 2'b00;
    case (st)
      4'h0: begin req = 1; irw = rdy; pcw = rdy; b = 2'b10; rs = 2'b10; end
      4'h1: begin a = 2'b01; b = 2'b01; end
      4'h2: begin a = 2'b10; b = 2'b01; end
      4'h3: begin req = 1; adr = 1; end
      4'h4: begin rs = 2'b01; rw = 1; ret = 1; end
      4'h5: begin req = 1; we = 1; adr = 1; ret = rdy; end
      4'h6: begin a = 2'b10; op = 2'b10; end
      4'h7: begin a = 2'b10; b = 2'b01; op = 2'b11; end
      4'h8: begin rw = 1; ret = 1; end
      4'h9: begin a = 2'b10; op = 2'b01; pcw = tk; ret = 1; end
      4'hA: begin pcw = 1; a = 2'b01; b = 2'b10; end
      4'hB: begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1; end
      4'hC: begin a = 2'b01; b = 2'b10; end
      4'hD: begin a = 2'b11; b = 2'b01; end
      default: hlt = 1;
    endcase
    return {req, we, adr, irw, pcw, a, b, op, rs, rw, ret, hlt, ill};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    do_reset();
    e = exp_out(4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (state !== 4'h0) begin n_fails++; $display("FAIL reset_state got %h exp 0", state); end
    n_checks++;
    if (outs !== e) begin n_fails++; $display("FAIL reset_outs got %b exp %b", outs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [3:0] s[$] = '{4'h0, 4'h1, 4'h6, 4'h8, 4'h0};
    logic       r[$] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    do_reset();
    opcode = 7'b0110011;
    for (int i = 0; i < s.size(); i++) begin
      sb.push_back('{st: s[i], rdy: r[i], tk: 1'b0, ill: 1'b0});
      mem_ready = r[i];
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL rtype_state cyc%0d got %h exp %h", i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL rtype_outs cyc%0d got %b exp %b", i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [3:0] s[$] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h0};
    logic       r[$] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t e;
    do_reset();
    opcode = 7'b0000011;
    for (int i = 0; i < s.size(); i++) begin
      sb.push_back('{st: s[i], rdy: r[i], tk: 1'b0, ill: 1'b0});
      mem_ready = r[i];
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL load_state cyc%0d got %h exp %h", i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL load_outs cyc%0d got %b exp %b", i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_wait();
    logic [3:0] s[$] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h5, 4'h5, 4'h0};
    logic       r[$] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t e;
    do_reset();
    opcode = 7'b0100011;
    for (int i = 0; i < s.size(); i++) begin
      sb.push_back('{st: s[i], rdy: r[i], tk: 1'b0, ill: 1'b0});
      mem_ready = r[i];
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL store_state cyc%0d got %h exp %h", i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL store_outs cyc%0d got %b exp %b", i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch(input logic taken);
    logic [3:0] s[$] = '{4'h0, 4'h1, 4'h9, 4'h0};
    logic       r[$] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    do_reset();
    opcode = 7'b1100011;
    branch_taken = taken;
    for (int i = 0; i < s.size(); i++) begin
      sb.push_back('{st: s[i], rdy: r[i], tk: taken, ill: 1'b0});
      mem_ready = r[i];
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL branch%0d_state cyc%0d got %h exp %h", taken, i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL branch%0d_outs cyc%0d got %b exp %b", taken, i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      @(posedge clk); #1;
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_jumps();
    logic [3:0] s[$] = '{4'h0, 4'h1, 4'hB, 4'hC, 4'h8, 4'h0, 4'h1, 4'hA, 4'h8, 4'h0};
    exp_t e;
    do_reset();
    for (int i = 0; i < s.size(); i++) begin
      if (i == 0) opcode = 7'b1100111;
      if (i == 5) opcode = 7'b1101111;
      sb.push_back('{st: s[i], rdy: (i != 9), tk: 1'b0, ill: 1'b0});
      mem_ready = (i != 9);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL jump_state cyc%0d got %h exp %h", i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL jump_outs cyc%0d got %b exp %b", i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s[$] = '{4'h0, 4'h1, 4'hD, 4'h8, 4'h0, 4'h1, 4'h8, 4'h0, 4'h1, 4'h7, 4'h8, 4'h0};
    exp_t e;
    int   retires = 0;
    do_reset();
    for (int i = 0; i < s.size(); i++) begin
      if (i == 0) opcode = 7'b0110111;
      if (i == 4) opcode = 7'b0010111;
      if (i == 7) opcode = 7'b0010011;
      sb.push_back('{st: s[i], rdy: (i != 11), tk: 1'b0, ill: 1'b0});
      mem_ready = (i != 11);
      @(negedge clk);
      e = sb.pop_front();
      if (retire === 1'b1) retires++;
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL b2b_state cyc%0d got %h exp %h", i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL b2b_outs cyc%0d got %b exp %b", i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (retires != 3) begin n_fails++; $display("FAIL b2b_retire_count got %0d exp 3", retires); end
  endtask

  task automatic test_halt(input logic [6:0] op, input logic exp_ill);
    exp_t e;
    logic [3:0] st;
    int   retires = 0;
    do_reset();
    opcode = op;
    for (int i = 0; i < 14; i++) begin
      st = (i == 0) ? 4'h0 : (i == 1) ? 4'h1 : 4'hF;
      sb.push_back('{st: st, rdy: 1'b1, tk: 1'b0, ill: exp_ill && (st == 4'hF)});
      mem_ready = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      if (retire === 1'b1) retires++;
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL halt_%b_state cyc%0d got %h exp %h", op, i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL halt_%b_outs cyc%0d got %b exp %b", op, i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (retires != 0) begin n_fails++; $display("FAIL halt_%b_retire got %0d exp 0", op, retires); end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (state !== 4'h0 || illegal !== 1'b0 || halted !== 1'b0) begin
      n_fails++; $display("FAIL halt_%b_recover got st=%h ill=%b hlt=%b exp st=0 ill=0 hlt=0", op, state, illegal, halted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_store();
    logic [3:0] s[$] = '{4'h0, 4'h1, 4'h2, 4'h5};
    logic       r[$] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    do_reset();
    opcode = 7'b0100011;
    for (int i = 0; i < s.size(); i++) begin
      sb.push_back('{st: s[i], rdy: r[i], tk: 1'b0, ill: 1'b0});
      mem_ready = r[i];
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (state !== e.st) begin n_fails++; $display("FAIL rststore_state cyc%0d got %h exp %h", i, state, e.st); end
      n_checks++;
      if (outs !== exp_out(e.st, e.rdy, e.tk, e.ill)) begin
        n_fails++; $display("FAIL rststore_outs cyc%0d got %b exp %b", i, outs, exp_out(e.st, e.rdy, e.tk, e.ill));
      end
      if (i == s.size() - 1) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 4'h0 || mem_we !== 1'b0 || retire !== 1'b0 || mem_req !== 1'b1) begin
      n_fails++; $display("FAIL rststore_after got st=%h we=%b ret=%b req=%b exp st=0 we=0 ret=0 req=1",
                          state, mem_we, retire, mem_req);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_wait();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jumps();
    test_back_to_back();
    test_halt(7'b1111111, 1'b1);
    test_halt(7'b1110011, 1'b0);
    test_reset_in_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
